// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter.
// Generates SCK / WS / SD from the system clock and serialises stereo samples MSB first.
// Samples enter through a valid/ready handshake into a one-deep holding buffer that is
// moved into the frame shift register at each frame load; an empty buffer sends silence.
//
// Optional build macro: I2S_TX_MONO_EN -- in_left is sent in both slots, in_right ignored.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   en                    transmit enable (sampled at frame boundaries)
//   ws_align              0: standard I2S (WS one SCK early), 1: left-justified
//   in_left, in_right     sample pair, in_valid / in_ready handshake
//   i2s_clk, i2s_ws, i2s_dout   serial link (SCK, WS, SD)
//   frame_start           1-cycle pulse on each frame load
//   underflow             1-cycle pulse when a frame loads with the holding buffer empty
module i2s_tx #(
  parameter int unsigned DW      = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          ws_align,
  input  logic [DW-1:0] in_left,
  input  logic [DW-1:0] in_right,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          i2s_clk,
  output logic          i2s_ws,
  output logic          i2s_dout,
  output logic          frame_start,
  output logic          underflow
);

  localparam int unsigned FW = 2 * DW;
  localparam int unsigned PW = $clog2(FW);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_div, w_div_next;
  logic [PW-1:0]   r_pos, w_pos_next;
  logic [FW-1:0]   r_shift, w_shift_next;
  logic            r_sck, w_sck_next;
  logic            r_ws, w_ws_next;
  logic            r_dout, w_dout_next;
  logic            r_align, w_align_next;
  logic            r_fs, w_fs_next;
  logic            r_uf, w_uf_next;
  logic            r_hold_full, w_hold_full_next;
  logic [DW-1:0]   r_hold_l;
  logic            w_load;
  logic            w_accept;
  logic [FW-1:0]   w_load_data;

  // WS for bit position q: left-justified follows the slot, standard I2S leads by one bit.
  function automatic logic ws_of(input logic [PW-1:0] q, input logic align);
    if (align) return (q >= PW'(DW));
    return (q >= PW'(DW - 1)) && (q != PW'(FW - 1));
  endfunction

  assign w_accept = in_valid & ~r_hold_full;

`ifdef I2S_TX_MONO_EN
  assign w_load_data = r_hold_full ? {r_hold_l, r_hold_l} : '0;
`else
  logic [DW-1:0] r_hold_r;
  assign w_load_data = r_hold_full ? {r_hold_l, r_hold_r} : '0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_pos_next   = r_pos;
    w_shift_next = r_shift;
    w_sck_next   = r_sck;
    w_ws_next    = r_ws;
    w_dout_next  = r_dout;
    w_align_next = r_align;
    w_fs_next    = 1'b0;
    w_uf_next    = 1'b0;
    w_load       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (en) begin
          w_load       = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (r_div == CW'(CLK_DIV - 1)) begin
          w_div_next = '0;
          w_sck_next = ~r_sck;
          if (r_sck) begin
            // Falling SCK: advance to the next bit or close the frame.
            if (r_pos == PW'(FW - 1)) begin
              if (en) begin
                w_load = 1'b1;
              end else begin
                w_state_next = StIdle;
                w_ws_next    = 1'b0;
                w_dout_next  = 1'b0;
              end
            end else begin
              w_pos_next   = r_pos + PW'(1);
              w_dout_next  = r_shift[FW-1];
              w_shift_next = {r_shift[FW-2:0], 1'b0};
              w_ws_next    = ws_of(r_pos + PW'(1), r_align);
            end
          end
        end else begin
          w_div_next = r_div + CW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_load) begin
      w_pos_next   = '0;
      w_div_next   = '0;
      w_sck_next   = 1'b0;
      w_align_next = ws_align;
      w_dout_next  = w_load_data[FW-1];
      w_shift_next = {w_load_data[FW-2:0], 1'b0};
      w_ws_next    = ws_of('0, ws_align);
      w_fs_next    = 1'b1;
      w_uf_next    = ~r_hold_full;
    end

    // A load empties the buffer; an accept on that same edge refills it for the next frame.
    w_hold_full_next = w_load ? w_accept : (r_hold_full | w_accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_div       <= '0;
      r_pos       <= '0;
      r_shift     <= '0;
      r_sck       <= 1'b0;
      r_ws        <= 1'b0;
      r_dout      <= 1'b0;
      r_align     <= 1'b0;
      r_fs        <= 1'b0;
      r_uf        <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_div       <= w_div_next;
      r_pos       <= w_pos_next;
      r_shift     <= w_shift_next;
      r_sck       <= w_sck_next;
      r_ws        <= w_ws_next;
      r_dout      <= w_dout_next;
      r_align     <= w_align_next;
      r_fs        <= w_fs_next;
      r_uf        <= w_uf_next;
      r_hold_full <= w_hold_full_next;
      if (w_accept) r_hold_l <= in_left;
    end
  end

`ifndef I2S_TX_MONO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_r <= '0;
    end else if (w_accept) begin
      r_hold_r <= in_right;
    end
  end
`endif

  assign in_ready    = ~r_hold_full;
  assign i2s_clk     = r_sck;
  assign i2s_ws      = r_ws;
  assign i2s_dout    = r_dout;
  assign frame_start = r_fs;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
  localparam int DW      = 16;
  localparam int CLK_DIV = 2;

  logic          clk = 1'b0;
  logic          rst_n, en, ws_align, in_valid;
  logic [DW-1:0] in_left, in_right;
  logic          in_ready, i2s_clk, i2s_ws, i2s_dout, frame_start, underflow;

  i2s_tx #(.DW(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ws_align   (ws_align),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .i2s_clk    (i2s_clk),
    .i2s_ws     (i2s_ws),
    .i2s_dout   (i2s_dout),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  bit   prev_sck;
  logic cap_bits[$];
  logic cap_ws[$];
  int   acc_cyc[$];
  int   fs_cnt, uf_cnt, uf_alone, acc_cnt;

  // Expected right-slot content for the build under test.
  function automatic logic [DW-1:0] exp_r(input logic [DW-1:0] l, input logic [DW-1:0] r);
`ifdef I2S_TX_MONO_EN
    return l;
`else
    return r;
`endif
  endfunction

  // 32 captured values starting at index start; sel=0 data, sel=1 WS. Missing bits are x.
  function automatic logic [31:0] cap_word(input int start, input bit sel);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      if (start + i < cap_bits.size()) w[31-i] = sel ? cap_ws[start+i] : cap_bits[start+i];
      else w[31-i] = 1'bx;
    end
    return w;
  endfunction

  // One clock: sample #1 after the edge, log handshakes, pulses and rising-SCK bits.
  task automatic tick();
    logic acc_pre;
    acc_pre = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc_pre) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
    if (frame_start) fs_cnt++;
    if (underflow) begin
      uf_cnt++;
      if (!frame_start) uf_alone++;
    end
    if (!prev_sck && i2s_clk) begin
      cap_bits.push_back(i2s_dout);
      cap_ws.push_back(i2s_ws);
    end
    prev_sck = i2s_clk;
    cyc++;
  endtask

  task automatic clear_cap();
    cyc = 0;
    prev_sck = i2s_clk;
    cap_bits.delete();
    cap_ws.delete();
    acc_cyc.delete();
    fs_cnt = 0; uf_cnt = 0; uf_alone = 0; acc_cnt = 0;
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    in_left = l; in_right = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; ws_align = 1'b0;
    in_left = '0; in_right = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_cap();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (i2s_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", i2s_clk); end
    if (i2s_ws !== 1'b0) begin n_fail++; $display("FAIL reset_ws: got %b want 0", i2s_ws); end
    if (i2s_dout !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b want 0", i2s_dout); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b want 0", underflow); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stereo(input logic align);
    logic [31:0] exp_ws;
    exp_ws = align ? 32'h0000FFFF : 32'h0001FFFE;
    do_reset();
    ws_align = align;
    push(16'hA55A, 16'h0F0F);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL st%0d_full: got %b want 0", align, in_ready); end
    en = 1'b1;
    tick();
    en = 1'b0;
    n_checks += 2;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL st%0d_fs: got %b want 1", align, frame_start); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL st%0d_ready: got %b want 1", align, in_ready); end
    repeat (140) tick();
    n_checks += 7;
    if (cap_bits.size() != 32) begin n_fail++; $display("FAIL st%0d_nbits: got %0d want 32", align, cap_bits.size()); end
    if (cap_word(0, 0) !== {16'hA55A, exp_r(16'hA55A, 16'h0F0F)}) begin
      n_fail++; $display("FAIL st%0d_data: got %h want %h", align, cap_word(0, 0), {16'hA55A, exp_r(16'hA55A, 16'h0F0F)});
    end
    if (cap_word(0, 1) !== exp_ws) begin n_fail++; $display("FAIL st%0d_ws: got %h want %h", align, cap_word(0, 1), exp_ws); end
    if (fs_cnt != 1) begin n_fail++; $display("FAIL st%0d_fscnt: got %0d want 1", align, fs_cnt); end
    if (uf_cnt != 0) begin n_fail++; $display("FAIL st%0d_ufcnt: got %0d want 0", align, uf_cnt); end
    if ({i2s_clk, i2s_ws, i2s_dout} !== 3'b000) begin
      n_fail++; $display("FAIL st%0d_idle: got %b want 000", align, {i2s_clk, i2s_ws, i2s_dout});
    end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL st%0d_uf: got %b want 0", align, underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c == 192) begin in_left = 16'h8001; in_right = 16'h7FFF; in_valid = 1'b1; end
      if (c == 193) in_valid = 1'b0;
      if (c == 257) en = 1'b0;
      tick();
    end
    n_checks += 8;
    if (cap_bits.size() != 96) begin n_fail++; $display("FAIL uf_nbits: got %0d want 96", cap_bits.size()); end
    if (cap_word(0, 0) !== 32'h0) begin n_fail++; $display("FAIL uf_frame0: got %h want 0", cap_word(0, 0)); end
    if (cap_word(32, 0) !== 32'h0) begin n_fail++; $display("FAIL uf_frame1: got %h want 0", cap_word(32, 0)); end
    if (cap_word(64, 0) !== {16'h8001, exp_r(16'h8001, 16'h7FFF)}) begin
      n_fail++; $display("FAIL uf_frame2: got %h want %h", cap_word(64, 0), {16'h8001, exp_r(16'h8001, 16'h7FFF)});
    end
    if (fs_cnt != 3) begin n_fail++; $display("FAIL uf_fscnt: got %0d want 3", fs_cnt); end
    if (uf_cnt != 2) begin n_fail++; $display("FAIL uf_ufcnt: got %0d want 2", uf_cnt); end
    if (uf_alone != 0) begin n_fail++; $display("FAIL uf_alone: got %0d want 0", uf_alone); end
    if (acc_cnt != 1) begin n_fail++; $display("FAIL uf_acc: got %0d want 1", acc_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] tl[4];
    logic [DW-1:0] tr[4];
    int k;
    int last_acc;
    tl = '{16'h1111, 16'h3333, 16'h5555, 16'h7777};
    tr = '{16'h2222, 16'h4444, 16'h6666, 16'h8888};
    do_reset();
    k = 0;
    in_left = tl[0]; in_right = tr[0]; in_valid = 1'b1; en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c == 260) en = 1'b0;
      if (c == 300) in_valid = 1'b0;
      last_acc = acc_cnt;
      tick();
      if (acc_cnt != last_acc && k < 3) begin
        k++;
        in_left = tl[k]; in_right = tr[k];
      end
    end
    n_checks += 11;
    if (acc_cnt != 3) begin n_fail++; $display("FAIL b2b_acc: got %0d want 3", acc_cnt); end
    if (acc_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_acclog: got %0d want 3", acc_cyc.size()); end
    else begin
      if (acc_cyc[0] != 0) begin n_fail++; $display("FAIL b2b_acc0: got %0d want 0", acc_cyc[0]); end
      if (acc_cyc[1] != 129) begin n_fail++; $display("FAIL b2b_acc1: got %0d want 129", acc_cyc[1]); end
      if (acc_cyc[2] != 257) begin n_fail++; $display("FAIL b2b_acc2: got %0d want 257", acc_cyc[2]); end
    end
    if (fs_cnt != 3) begin n_fail++; $display("FAIL b2b_fscnt: got %0d want 3", fs_cnt); end
    if (uf_cnt != 1) begin n_fail++; $display("FAIL b2b_ufcnt: got %0d want 1", uf_cnt); end
    if (cap_word(0, 0) !== 32'h0) begin n_fail++; $display("FAIL b2b_frame0: got %h want 0", cap_word(0, 0)); end
    if (cap_word(32, 0) !== {tl[0], exp_r(tl[0], tr[0])}) begin
      n_fail++; $display("FAIL b2b_frame1: got %h want %h", cap_word(32, 0), {tl[0], exp_r(tl[0], tr[0])});
    end
    if (cap_word(64, 0) !== {tl[1], exp_r(tl[1], tr[1])}) begin
      n_fail++; $display("FAIL b2b_frame2: got %h want %h", cap_word(64, 0), {tl[1], exp_r(tl[1], tr[1])});
    end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_en_drop();
    do_reset();
    push(16'hC3C3, 16'h3C3C);
    clear_cap();
    en = 1'b1;
    for (int c = 0; c < 150; c++) begin
      if (c == 21) en = 1'b0;
      tick();
    end
    n_checks += 4;
    if (cap_bits.size() != 32) begin n_fail++; $display("FAIL en_nbits: got %0d want 32", cap_bits.size()); end
    if (cap_word(0, 0) !== {16'hC3C3, exp_r(16'hC3C3, 16'h3C3C)}) begin
      n_fail++; $display("FAIL en_data: got %h want %h", cap_word(0, 0), {16'hC3C3, exp_r(16'hC3C3, 16'h3C3C)});
    end
    if (fs_cnt != 1) begin n_fail++; $display("FAIL en_fscnt: got %0d want 1", fs_cnt); end
    if ({i2s_clk, i2s_ws, i2s_dout} !== 3'b000) begin
      n_fail++; $display("FAIL en_idle: got %b want 000", {i2s_clk, i2s_ws, i2s_dout});
    end
  endtask

  task automatic test_mono();
    do_reset();
    push(16'h1234, 16'hFFFF);
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (140) tick();
    n_checks += 2;
    if (cap_bits.size() != 32) begin n_fail++; $display("FAIL mono_nbits: got %0d want 32", cap_bits.size()); end
    if (cap_word(0, 0) !== {16'h1234, exp_r(16'h1234, 16'hFFFF)}) begin
      n_fail++; $display("FAIL mono_data: got %h want %h", cap_word(0, 0), {16'h1234, exp_r(16'h1234, 16'hFFFF)});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(16'h1357, 16'h2468);
    clear_cap();
    en = 1'b1;
    for (int c = 0; c < 83; c++) begin
      if (c == 10) begin in_left = 16'h9ABC; in_right = 16'hDEF0; in_valid = 1'b1; end
      if (c == 11) in_valid = 1'b0;
      tick();
    end
    // Bit 20 is on the bus with SCK high; right slot so WS is high.
    n_checks += 3;
    if (i2s_clk !== 1'b1) begin n_fail++; $display("FAIL mid_sck: got %b want 1", i2s_clk); end
    if (i2s_ws !== 1'b1) begin n_fail++; $display("FAIL mid_ws: got %b want 1", i2s_ws); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (i2s_clk !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b want 0", i2s_clk); end
    if (i2s_ws !== 1'b0) begin n_fail++; $display("FAIL rst_ws: got %b want 0", i2s_ws); end
    if (i2s_dout !== 1'b0) begin n_fail++; $display("FAIL rst_sd: got %b want 0", i2s_dout); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_uf: got %b want 0", underflow); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    clear_cap();
    repeat (10) tick();
    n_checks++;
    if (fs_cnt != 0 || i2s_clk !== 1'b0) begin
      n_fail++; $display("FAIL rst_stays_idle: got fs=%0d sck=%b want fs=0 sck=0", fs_cnt, i2s_clk);
    end
  endtask

  initial begin
    test_reset();
    test_stereo(1'b0);
    test_stereo(1'b1);
    test_underflow();
    test_back_to_back();
    test_en_drop();
    test_mono();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
